writeback_arb: RTL and testbench

WRITEBACK_ARB -- requirements
Module: writeback_arb

---
 rtl/writeback_arb_pkg.sv | 27 ++
 rtl/writeback_arb_fifo.sv | 71 +++++++
 rtl/writeback_arb.sv | 132 +++++++++++++
 tb/tb_writeback_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arb_pkg.sv
// Shared definitions for the writeback arbiter.
// Holds the ROB tag and data widths, the source index constants and the
// buffered result entry type used by the per-source FIFOs and the arbiter.
package writeback_arb_pkg;

  localparam int ROB_W   = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 4;

  // Source indices; round-robin order follows the index order.
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_BRU = 2'd3;

  typedef struct packed {
    logic [ROB_W-1:0]  dst_rob;
    logic [DATA_W-1:0] value;
    logic              lsmiss;
  } wb_entry_t;

  // Next source in round-robin order (wraps bru -> alu).
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/writeback_arb_fifo.sv
// Per-source result buffer for the writeback arbiter.
//   i_clk     clock, all state on rising edge
//   i_resetn  synchronous active-low reset
//   i_flush   empties the buffer; wins over push and pop
//   i_push    write i_data (ignored while full)
//   i_pop     drop the head entry (ignored while empty)
//   i_data    entry to write
//   o_head    current head entry (valid when o_count != 0)
//   o_count   number of occupied entries, 0..DEPTH
//   o_readyn  buffer full, pushes refused
module writeback_arb_fifo
  import writeback_arb_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  wb_entry_t     i_data,
  output wb_entry_t     o_head,
  output logic [CW-1:0] o_count,
  output logic          o_readyn
);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Full is decoded from the registered count only, so readyn never
  // depends combinationally on this cycle's inputs.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = i_push & ~w_full  & ~i_flush;
  assign w_pop    = i_pop  & ~w_empty & ~i_flush;

  assign o_head   = r_mem[r_rptr];
  assign o_count  = r_count;
  assign o_readyn = w_full;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (!i_resetn || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge i_clk) begin
    if (w_push && i_resetn) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/writeback_arb.sv
// Writeback arbiter: four execution pipes (alu, mul, mem, bru) each feed a
// small result FIFO; a round-robin arbiter pops one head per cycle onto the
// registered writeback bus (wb_*), which drives issue wake-up and the ROB.
//   clk, resetn        clock, synchronous active-low reset
//   snoop_hit          pipeline flush: empties all FIFOs, kills wb_en
//   <src>_valid/_dst_rob/_value   result from each pipe
//   mem_lsmiss         memory result missed (carried to wb_lsmiss)
//   <src>_readyn       per-source FIFO full, push refused
//   wb_en/_dst_rob/_value/_lsmiss  registered writeback
module writeback_arb
  import writeback_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              snoop_hit,
  input  logic              alu_valid,
  input  logic              mul_valid,
  input  logic              mem_valid,
  input  logic              bru_valid,
  input  logic [ROB_W-1:0]  alu_dst_rob,
  input  logic [ROB_W-1:0]  mul_dst_rob,
  input  logic [ROB_W-1:0]  mem_dst_rob,
  input  logic [ROB_W-1:0]  bru_dst_rob,
  input  logic [DATA_W-1:0] alu_value,
  input  logic [DATA_W-1:0] mul_value,
  input  logic [DATA_W-1:0] mem_value,
  input  logic [DATA_W-1:0] bru_value,
  input  logic              mem_lsmiss,
  output logic              alu_readyn,
  output logic              mul_readyn,
  output logic              mem_readyn,
  output logic              bru_readyn,
  output logic              wb_en,
  output logic [ROB_W-1:0]  wb_dst_rob,
  output logic [DATA_W-1:0] wb_value,
  output logic              wb_lsmiss
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic      [NUM_SRC-1:0]         w_valid;
  wb_entry_t [NUM_SRC-1:0]         w_data;
  wb_entry_t [NUM_SRC-1:0]         w_head;
  logic      [NUM_SRC-1:0][CW-1:0] w_count;
  logic      [NUM_SRC-1:0]         w_readyn;
  logic      [NUM_SRC-1:0]         w_empty;
  logic      [NUM_SRC-1:0]         w_push;
  logic      [NUM_SRC-1:0]         w_pop;

  logic                            w_gnt_vld;
  logic      [1:0]                 w_gnt_idx;

  logic      [1:0]                 r_rr_ptr;   // first source to consider
  logic                            r_wb_en;
  wb_entry_t                       r_wb;

  // Gather per-source inputs; only the memory pipe can report a miss.
  assign w_valid = {bru_valid, mem_valid, mul_valid, alu_valid};
  assign w_data[SRC_ALU] = '{dst_rob: alu_dst_rob, value: alu_value, lsmiss: 1'b0};
  assign w_data[SRC_MUL] = '{dst_rob: mul_dst_rob, value: mul_value, lsmiss: 1'b0};
  assign w_data[SRC_MEM] = '{dst_rob: mem_dst_rob, value: mem_value, lsmiss: mem_lsmiss};
  assign w_data[SRC_BRU] = '{dst_rob: bru_dst_rob, value: bru_value, lsmiss: 1'b0};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : gen_src
      assign w_empty[g] = (w_count[g] == '0);
      // snoop_hit outranks push and pop; the FIFO also sees it as flush.
      assign w_push[g]  = w_valid[g] & ~w_readyn[g] & ~snoop_hit;
      assign w_pop[g]   = w_gnt_vld & (w_gnt_idx == 2'(g)) & ~snoop_hit;

      writeback_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_flush  (snoop_hit),
        .i_push   (w_push[g]),
        .i_pop    (w_pop[g]),
        .i_data   (w_data[g]),
        .o_head   (w_head[g]),
        .o_count  (w_count[g]),
        .o_readyn (w_readyn[g])
      );
    end
  endgenerate

  // Round-robin search starting at r_rr_ptr; first non-empty source wins.
  always_comb begin
    logic [1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = r_rr_ptr + 2'(k);
      if (!w_gnt_vld && !w_empty[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // Writeback register and arbiter pointer. Data holds when nothing is
  // granted or on a flush; only wb_en is cleared.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rr_ptr <= SRC_ALU;
      r_wb_en  <= 1'b0;
      r_wb     <= '0;
    end else if (snoop_hit) begin
      r_rr_ptr <= SRC_ALU;
      r_wb_en  <= 1'b0;
    end else begin
      r_wb_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_wb     <= w_head[w_gnt_idx];
        r_rr_ptr <= next_src(w_gnt_idx);
      end
    end
  end

  assign alu_readyn = w_readyn[SRC_ALU];
  assign mul_readyn = w_readyn[SRC_MUL];
  assign mem_readyn = w_readyn[SRC_MEM];
  assign bru_readyn = w_readyn[SRC_BRU];

  assign wb_en      = r_wb_en;
  assign wb_dst_rob = r_wb.dst_rob;
  assign wb_value   = r_wb.value;
  assign wb_lsmiss  = r_wb.lsmiss;

endmodule

// File: tb/tb_writeback_arb.sv
module tb_writeback_arb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn, snoop_hit;
  logic        alu_valid, mul_valid, mem_valid, bru_valid;
  logic [3:0]  alu_dst_rob, mul_dst_rob, mem_dst_rob, bru_dst_rob;
  logic [31:0] alu_value, mul_value, mem_value, bru_value;
  logic        mem_lsmiss;
  logic        alu_readyn, mul_readyn, mem_readyn, bru_readyn;
  logic        wb_en;
  logic [3:0]  wb_dst_rob;
  logic [31:0] wb_value;
  logic        wb_lsmiss;

  int tests = 0;
  int fails = 0;

  writeback_arb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit),
    .alu_valid(alu_valid), .mul_valid(mul_valid), .mem_valid(mem_valid), .bru_valid(bru_valid),
    .alu_dst_rob(alu_dst_rob), .mul_dst_rob(mul_dst_rob), .mem_dst_rob(mem_dst_rob), .bru_dst_rob(bru_dst_rob),
    .alu_value(alu_value), .mul_value(mul_value), .mem_value(mem_value), .bru_value(bru_value),
    .mem_lsmiss(mem_lsmiss),
    .alu_readyn(alu_readyn), .mul_readyn(mul_readyn), .mem_readyn(mem_readyn), .bru_readyn(bru_readyn),
    .wb_en(wb_en), .wb_dst_rob(wb_dst_rob), .wb_value(wb_value), .wb_lsmiss(wb_lsmiss)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: queues + rotating priority ----------
  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
    logic        miss;
  } ent_t;

  ent_t        mq[4][$];
  int          m_rr;
  logic        m_en;
  logic [3:0]  m_rob;
  logic [31:0] m_val;
  logic        m_miss;
  bit          m_live = 0;

  task automatic model_step();
    bit   vld[4];
    ent_t inp[4];
    bit   full[4];
    int   gsrc;
    ent_t e;
    vld[0] = alu_valid; inp[0] = '{alu_dst_rob, alu_value, 1'b0};
    vld[1] = mul_valid; inp[1] = '{mul_dst_rob, mul_value, 1'b0};
    vld[2] = mem_valid; inp[2] = '{mem_dst_rob, mem_value, mem_lsmiss};
    vld[3] = bru_valid; inp[3] = '{bru_dst_rob, bru_value, 1'b0};
    if (!resetn) begin
      for (int s = 0; s < 4; s++) mq[s].delete();
      m_rr = 0; m_en = 0; m_rob = 0; m_val = 0; m_miss = 0; m_live = 1;
    end else if (snoop_hit) begin
      for (int s = 0; s < 4; s++) mq[s].delete();
      m_rr = 0; m_en = 0;
    end else begin
      for (int s = 0; s < 4; s++) full[s] = (mq[s].size() == DEPTH);
      gsrc = -1;
      for (int k = 0; k < 4; k++)
        if (gsrc < 0 && mq[(m_rr + k) % 4].size() > 0) gsrc = (m_rr + k) % 4;
      if (gsrc >= 0) begin
        e = mq[gsrc].pop_front();
        m_en = 1; m_rob = e.rob; m_val = e.val; m_miss = e.miss;
        m_rr = (gsrc + 1) % 4;
      end else begin
        m_en = 0;
      end
      for (int s = 0; s < 4; s++)
        if (vld[s] && !full[s]) mq[s].push_back(inp[s]);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_compare();
    logic [3:0] rdy_exp;
    if (!m_live) return;
    for (int s = 0; s < 4; s++) rdy_exp[s] = (mq[s].size() == DEPTH);
    chk("m_wb_en", 32'(wb_en), 32'(m_en));
    chk("m_wb_rob", 32'(wb_dst_rob), 32'(m_rob));
    chk("m_wb_value", wb_value, m_val);
    chk("m_wb_lsmiss", 32'(wb_lsmiss), 32'(m_miss));
    chk("m_readyn", 32'({bru_readyn, mem_readyn, mul_readyn, alu_readyn}), 32'(rdy_exp));
  endtask

  // One clock: model and DUT see the same inputs at the edge, outputs are
  // compared 1 time unit later, inputs may change from +3 onward.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    model_compare();
    #2;
  endtask

  task automatic clr_in();
    snoop_hit = 0; mem_lsmiss = 0;
    alu_valid = 0; mul_valid = 0; mem_valid = 0; bru_valid = 0;
  endtask

  task automatic drv(input int s, input logic [3:0] rob, input logic [31:0] v, input logic miss);
    case (s)
      0: begin alu_valid = 1; alu_dst_rob = rob; alu_value = v; end
      1: begin mul_valid = 1; mul_dst_rob = rob; mul_value = v; end
      2: begin mem_valid = 1; mem_dst_rob = rob; mem_value = v; mem_lsmiss = miss; end
      default: begin bru_valid = 1; bru_dst_rob = rob; bru_value = v; end
    endcase
  endtask

  task automatic do_reset();
    clr_in(); resetn = 0; cyc(); resetn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    alu_dst_rob = 0; mul_dst_rob = 0; mem_dst_rob = 0; bru_dst_rob = 0;
    alu_value = 0; mul_value = 0; mem_value = 0; bru_value = 0;
    clr_in();
    resetn = 0;
    // inputs during reset are ignored
    for (int s = 0; s < 4; s++) drv(s, 4'(s + 8), 32'hA000_0000 + s, 1'b1);
    cyc(); cyc();
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_rob", 32'(wb_dst_rob), 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_readyn", 32'({bru_readyn, mem_readyn, mul_readyn, alu_readyn}), 0);
    resetn = 1; clr_in();
    cyc();

    // single alu result, latency check
    drv(0, 4'd3, 32'hDEADBEEF, 1'b0);
    cyc();
    chk("lat_k_en", 32'(wb_en), 0);
    clr_in();
    cyc();
    chk("lat_k1_en", 32'(wb_en), 1);
    chk("lat_k1_rob", 32'(wb_dst_rob), 3);
    chk("lat_k1_value", wb_value, 32'hDEADBEEF);
    chk("lat_k1_miss", 32'(wb_lsmiss), 0);
    cyc();
    chk("idle_en", 32'(wb_en), 0);
    chk("idle_hold_value", wb_value, 32'hDEADBEEF);

    // all four sources at once: round-robin order from alu
    do_reset();
    for (int s = 0; s < 4; s++) drv(s, 4'(s + 1), 32'h100 * (s + 1), 1'b0);
    cyc();
    clr_in();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("rr4_en", 32'(wb_en), 1);
      chk("rr4_rob", 32'(wb_dst_rob), 32'(i));
    end
    cyc();
    chk("rr4_done_en", 32'(wb_en), 0);

    // mul backpressure with bru competing
    do_reset();
    drv(1, 4'd5, 32'h55, 0);                        // e1
    cyc(); clr_in();
    drv(1, 4'd6, 32'h66, 0); drv(3, 4'd9, 32'h99, 0); // e2
    cyc();
    chk("bp_e2_rob", 32'(wb_dst_rob), 5);
    clr_in();
    drv(1, 4'd7, 32'h77, 0); drv(3, 4'd10, 32'hAA, 0); // e3
    cyc();
    chk("bp_e3_readyn", 32'(mul_readyn), 1);
    chk("bp_e3_rob", 32'(wb_dst_rob), 9);
    clr_in();
    drv(1, 4'd8, 32'h88, 0);                        // e4: refused
    cyc();
    chk("bp_e4_readyn", 32'(mul_readyn), 0);
    chk("bp_e4_rob", 32'(wb_dst_rob), 6);
    clr_in();
    cyc();
    chk("bp_e5_rob", 32'(wb_dst_rob), 10);
    cyc();
    chk("bp_e6_rob", 32'(wb_dst_rob), 7);
    cyc();
    chk("bp_e7_en", 32'(wb_en), 0);

    // memory miss propagation
    do_reset();
    drv(2, 4'd7, 32'h7777, 1'b1);
    cyc(); clr_in();
    drv(0, 4'd2, 32'h2222, 1'b0);
    cyc();
    chk("miss_mem_flag", 32'(wb_lsmiss), 1);
    chk("miss_mem_rob", 32'(wb_dst_rob), 7);
    clr_in();
    cyc();
    chk("miss_alu_flag", 32'(wb_lsmiss), 0);
    chk("miss_alu_rob", 32'(wb_dst_rob), 2);

    // single source at full throughput
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clr_in(); drv(0, 4'(i + 1), 32'(i), 0); cyc();
    end
    clr_in();
    chk("tput_en", 32'(wb_en), 1);
    cyc(); cyc();

    // flush with buffered and same-cycle results
    do_reset();
    reached = 0;
    for (int i = 0; i < 8 && !reached; i++) begin
      drv(0, 4'(i), 32'hA0 + i, 0); drv(2, 4'(i), 32'hB0 + i, 0);
      cyc();
      reached = alu_readyn || mem_readyn;
    end
    chk("snoop_fill_reached", 32'(reached), 1);
    snoop_hit = 1;
    for (int s = 0; s < 4; s++) drv(s, 4'd15, 32'hF0F0_F0F0, 1'b1);
    cyc();
    chk("snoop_en", 32'(wb_en), 0);
    chk("snoop_readyn", 32'({bru_readyn, mem_readyn, mul_readyn, alu_readyn}), 0);
    clr_in();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("snoop_after_en", 32'(wb_en), 0);
    end

    // reset mid-traffic, then bru wins immediately
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 4; s++) drv(s, 4'(s + 4), 32'hC0 + i, 1'b1);
      cyc();
    end
    resetn = 0;
    cyc();
    chk("mrst_en", 32'(wb_en), 0);
    chk("mrst_rob", 32'(wb_dst_rob), 0);
    chk("mrst_value", wb_value, 0);
    chk("mrst_miss", 32'(wb_lsmiss), 0);
    chk("mrst_readyn", 32'({bru_readyn, mem_readyn, mul_readyn, alu_readyn}), 0);
    resetn = 1; clr_in();
    drv(3, 4'd11, 32'hB00B, 0);
    cyc(); clr_in();
    cyc();
    chk("mrst_bru_en", 32'(wb_en), 1);
    chk("mrst_bru_rob", 32'(wb_dst_rob), 11);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
